// File: rtl/centroid_updater.sv
// K-means centroid updater: accumulates per-cluster sums/counts over an epoch, then divides serially
// and streams new centroids. Define CENTROID_ROUNDING_EN for round-half-up means instead of floor.
module centroid_updater #(
    parameter int unsigned K       = 16,
    parameter int unsigned COORD_W = 6,
    parameter int unsigned CNT_W   = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 pt_valid_i,
    output logic                 pt_ready_o,
    input  logic [COORD_W-1:0]   pt_x_i,
    input  logic [COORD_W-1:0]   pt_y_i,
    input  logic [K-1:0]         pt_core_i,
    input  logic                 epoch_done_i,
    output logic                 cen_valid_o,
    input  logic                 cen_ready_i,
    output logic [$clog2(K)-1:0] cen_idx_o,
    output logic [COORD_W-1:0]   cen_x_o,
    output logic [COORD_W-1:0]   cen_y_o,
    output logic                 cen_empty_o,
    output logic                 busy_o,
    output logic                 sat_err_o
);
    localparam int unsigned IDX_W = $clog2(K);
    localparam int unsigned SUM_W = COORD_W + CNT_W;
`ifdef CENTROID_ROUNDING_EN
    localparam int unsigned DIV_W = SUM_W + 1;
`else
    localparam int unsigned DIV_W = SUM_W;
`endif
    localparam int unsigned STEP_W = $clog2(DIV_W + 1);

    typedef enum logic [1:0] {ACCUM, DIVIDE, EMIT} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   k_q, k_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [DIV_W-1:0]   dvd_x_q, dvd_x_d, dvd_y_q, dvd_y_d;
    logic [CNT_W-1:0]   rem_x_q, rem_x_d, rem_y_q, rem_y_d;
    logic [DIV_W-2:0]   quo_x_q, quo_x_d, quo_y_q, quo_y_d;
    logic               cen_valid_q, cen_valid_d;
    logic [IDX_W-1:0]   cen_idx_q, cen_idx_d;
    logic [COORD_W-1:0] cen_x_q, cen_x_d, cen_y_q, cen_y_d;
    logic               cen_empty_q, cen_empty_d;
    logic               busy_q, pt_ready_q, sat_err_q;

    logic [SUM_W-1:0]   sum_x_q [K];
    logic [SUM_W-1:0]   sum_y_q [K];
    logic [CNT_W-1:0]   cnt_q   [K];

    logic               hit, acc_en, sat_set, clr_all;
    logic [IDX_W-1:0]   sel;
    logic [CNT_W-1:0]   cnt_sel;
    logic [DIV_W-1:0]   rnd_add;
    logic [CNT_W:0]     rsh_x, rsh_y;
    logic               ge_x, ge_y;
    logic [DIV_W-1:0]   quo_x_nx, quo_y_nx;

    function automatic logic [COORD_W-1:0] clamp_mean(input logic [DIV_W-1:0] q);
        return (|q[DIV_W-1:COORD_W]) ? '1 : q[COORD_W-1:0];
    endfunction

    // Lowest set bit of the one-hot vector wins, matching the comparator tie rule
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = int'(K) - 1; i >= 0; i--) begin
            if (pt_core_i[i]) begin
                hit = 1'b1;
                sel = IDX_W'(i);
            end
        end
    end

    // One restoring-division step for each coordinate
    always_comb begin
        cnt_sel  = cnt_q[k_q];
        rsh_x    = {rem_x_q, dvd_x_q[DIV_W-1]};
        rsh_y    = {rem_y_q, dvd_y_q[DIV_W-1]};
        ge_x     = rsh_x >= {1'b0, cnt_sel};
        ge_y     = rsh_y >= {1'b0, cnt_sel};
        quo_x_nx = {quo_x_q, ge_x};
        quo_y_nx = {quo_y_q, ge_y};
`ifdef CENTROID_ROUNDING_EN
        rnd_add  = DIV_W'(cnt_sel >> 1);
`else
        rnd_add  = '0;
`endif
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        step_d      = step_q;
        dvd_x_d     = dvd_x_q;
        dvd_y_d     = dvd_y_q;
        rem_x_d     = rem_x_q;
        rem_y_d     = rem_y_q;
        quo_x_d     = quo_x_q;
        quo_y_d     = quo_y_q;
        cen_valid_d = cen_valid_q;
        cen_idx_d   = cen_idx_q;
        cen_x_d     = cen_x_q;
        cen_y_d     = cen_y_q;
        cen_empty_d = cen_empty_q;
        acc_en      = 1'b0;
        sat_set     = 1'b0;
        clr_all     = 1'b0;
        unique case (state_q)
            ACCUM: begin
                if (pt_valid_i && pt_ready_q && hit) begin
                    if (&cnt_q[sel]) sat_set = 1'b1;
                    else             acc_en  = 1'b1;
                end
                if (epoch_done_i) begin
                    state_d = DIVIDE;
                    k_d     = '0;
                    step_d  = '0;
                end
            end
            DIVIDE: begin
                if (step_q == '0) begin
                    cen_idx_d = k_q;
                    if (cnt_sel == '0) begin
                        cen_x_d     = '0;
                        cen_y_d     = '0;
                        cen_empty_d = 1'b1;
                        cen_valid_d = 1'b1;
                        state_d     = EMIT;
                    end else begin
                        dvd_x_d = DIV_W'(sum_x_q[k_q]) + rnd_add;
                        dvd_y_d = DIV_W'(sum_y_q[k_q]) + rnd_add;
                        rem_x_d = '0;
                        rem_y_d = '0;
                        quo_x_d = '0;
                        quo_y_d = '0;
                        step_d  = STEP_W'(1);
                    end
                end else begin
                    dvd_x_d = dvd_x_q << 1;
                    dvd_y_d = dvd_y_q << 1;
                    rem_x_d = ge_x ? CNT_W'(rsh_x - {1'b0, cnt_sel}) : CNT_W'(rsh_x);
                    rem_y_d = ge_y ? CNT_W'(rsh_y - {1'b0, cnt_sel}) : CNT_W'(rsh_y);
                    quo_x_d = quo_x_nx[DIV_W-2:0];
                    quo_y_d = quo_y_nx[DIV_W-2:0];
                    step_d  = step_q + STEP_W'(1);
                    if (step_q == STEP_W'(DIV_W)) begin
                        cen_x_d     = clamp_mean(quo_x_nx);
                        cen_y_d     = clamp_mean(quo_y_nx);
                        cen_empty_d = 1'b0;
                        cen_valid_d = 1'b1;
                        state_d     = EMIT;
                    end
                end
            end
            EMIT: begin
                if (cen_ready_i) begin
                    cen_valid_d = 1'b0;
                    if (k_q == IDX_W'(K - 1)) begin
                        clr_all = 1'b1;
                        state_d = ACCUM;
                    end else begin
                        k_d     = k_q + IDX_W'(1);
                        step_d  = '0;
                        state_d = DIVIDE;
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ACCUM;
            k_q         <= '0;
            step_q      <= '0;
            dvd_x_q     <= '0;
            dvd_y_q     <= '0;
            rem_x_q     <= '0;
            rem_y_q     <= '0;
            quo_x_q     <= '0;
            quo_y_q     <= '0;
            cen_valid_q <= 1'b0;
            cen_idx_q   <= '0;
            cen_x_q     <= '0;
            cen_y_q     <= '0;
            cen_empty_q <= 1'b0;
            busy_q      <= 1'b0;
            pt_ready_q  <= 1'b1;
            sat_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            step_q      <= step_d;
            dvd_x_q     <= dvd_x_d;
            dvd_y_q     <= dvd_y_d;
            rem_x_q     <= rem_x_d;
            rem_y_q     <= rem_y_d;
            quo_x_q     <= quo_x_d;
            quo_y_q     <= quo_y_d;
            cen_valid_q <= cen_valid_d;
            cen_idx_q   <= cen_idx_d;
            cen_x_q     <= cen_x_d;
            cen_y_q     <= cen_y_d;
            cen_empty_q <= cen_empty_d;
            busy_q      <= (state_d != ACCUM);
            pt_ready_q  <= (state_d == ACCUM);
            if (clr_all)      sat_err_q <= 1'b0;
            else if (sat_set) sat_err_q <= 1'b1;
        end
    end

    // Per-cluster accumulators; cleared on reset and after the last centroid is taken
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_all) begin
            for (int i = 0; i < int'(K); i++) begin
                sum_x_q[i] <= '0;
                sum_y_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
        end else if (acc_en) begin
            sum_x_q[sel] <= sum_x_q[sel] + SUM_W'(pt_x_i);
            sum_y_q[sel] <= sum_y_q[sel] + SUM_W'(pt_y_i);
            cnt_q[sel]   <= cnt_q[sel] + CNT_W'(1);
        end
    end

    assign pt_ready_o  = pt_ready_q;
    assign cen_valid_o = cen_valid_q;
    assign cen_idx_o   = cen_idx_q;
    assign cen_x_o     = cen_x_q;
    assign cen_y_o     = cen_y_q;
    assign cen_empty_o = cen_empty_q;
    assign busy_o      = busy_q;
    assign sat_err_o   = sat_err_q;

endmodule

// File: tb/tb_centroid_updater.sv
// Bench for centroid_updater: directed epochs plus random epochs against an arithmetic mean model.
module tb_centroid_updater;
    localparam int K       = 16;
    localparam int COORD_W = 6;
    localparam int CNT_W   = 12;
    localparam int SUM_W   = COORD_W + CNT_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef CENTROID_ROUNDING_EN
    localparam int DIV_W = SUM_W + 1;
`else
    localparam int DIV_W = SUM_W;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               pt_valid, pt_ready, epoch_done;
    logic [COORD_W-1:0] pt_x, pt_y;
    logic [K-1:0]       pt_core;
    logic               cen_valid, cen_ready, cen_empty, busy, sat_err;
    logic [3:0]         cen_idx;
    logic [COORD_W-1:0] cen_x, cen_y;

    int errors = 0;
    int checks = 0;

    centroid_updater dut (
        .clk_i(clk), .rst_i(rst),
        .pt_valid_i(pt_valid), .pt_ready_o(pt_ready),
        .pt_x_i(pt_x), .pt_y_i(pt_y), .pt_core_i(pt_core),
        .epoch_done_i(epoch_done),
        .cen_valid_o(cen_valid), .cen_ready_i(cen_ready),
        .cen_idx_o(cen_idx), .cen_x_o(cen_x), .cen_y_o(cen_y),
        .cen_empty_o(cen_empty), .busy_o(busy), .sat_err_o(sat_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    int msx[K], msy[K], mcnt[K];
    bit m_sat, m_busy;
    int m_wait;
    int q_idx[$], q_x[$], q_y[$], q_e[$];
    int got_x[K], got_y[K], got_e[K];

    function automatic int lowest(input logic [K-1:0] v);
        for (int i = 0; i < K; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int mean_of(input int s, input int c);
        int v;
`ifdef CENTROID_ROUNDING_EN
        v = (s + c / 2) / c;
        if (v > (1 << COORD_W) - 1) v = (1 << COORD_W) - 1;
`else
        v = s / c;
`endif
        return v;
    endfunction

    function automatic int lat(input int empty);
        return empty != 0 ? 1 : DIV_W + 1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < K; i++) begin
            msx[i] = 0; msy[i] = 0; mcnt[i] = 0;
        end
        m_sat = 1'b0;
    endtask

    // Compare process: checks every output each cycle, then advances the model from sampled inputs
    always @(negedge clk) begin : mon
        bit was_busy;
        int k;
        if (rst) begin
            model_clear();
            m_busy = 1'b0;
            m_wait = 0;
            q_idx.delete(); q_x.delete(); q_y.delete(); q_e.delete();
        end else begin
            was_busy = m_busy;
            chk("busy", 32'(busy), 32'(was_busy));
            chk("pt_ready", 32'(pt_ready), 32'(!was_busy));
            chk("sat_err", 32'(sat_err), 32'(m_sat));
            if (!was_busy) begin
                chk("cen_valid_idle", 32'(cen_valid), 0);
            end else if (m_wait > 0) begin
                chk("cen_valid_early", 32'(cen_valid), 0);
                m_wait--;
            end else begin
                chk("cen_valid", 32'(cen_valid), 1);
                chk("cen_idx", 32'(cen_idx), 32'(q_idx[0]));
                chk("cen_x", 32'(cen_x), 32'(q_x[0]));
                chk("cen_y", 32'(cen_y), 32'(q_y[0]));
                chk("cen_empty", 32'(cen_empty), 32'(q_e[0]));
                got_x[q_idx[0]] = int'(cen_x);
                got_y[q_idx[0]] = int'(cen_y);
                got_e[q_idx[0]] = int'(cen_empty);
                if (cen_ready) begin
                    void'(q_idx.pop_front()); void'(q_x.pop_front());
                    void'(q_y.pop_front()); void'(q_e.pop_front());
                    if (q_idx.size() == 0) begin
                        m_busy = 1'b0;
                        model_clear();
                    end else begin
                        m_wait = lat(q_e[0]);
                    end
                end
            end
            if (!was_busy) begin
                if (pt_valid) begin
                    k = lowest(pt_core);
                    if (k >= 0) begin
                        if (mcnt[k] == CNT_MAX) m_sat = 1'b1;
                        else begin
                            msx[k] += int'(pt_x); msy[k] += int'(pt_y); mcnt[k]++;
                        end
                    end
                end
                if (epoch_done) begin
                    for (int c = 0; c < K; c++) begin
                        q_idx.push_back(c);
                        if (mcnt[c] == 0) begin
                            q_x.push_back(0); q_y.push_back(0); q_e.push_back(1);
                        end else begin
                            q_x.push_back(mean_of(msx[c], mcnt[c]));
                            q_y.push_back(mean_of(msy[c], mcnt[c]));
                            q_e.push_back(0);
                        end
                    end
                    m_busy = 1'b1;
                    m_wait = lat(q_e[0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pt_valid = 1'b0; epoch_done = 1'b0;
        pt_x = '0; pt_y = '0; pt_core = '0;
    endtask

    task automatic send(input int x, input int y, input logic [K-1:0] core, input bit v, input bit ep);
        pt_valid = v; pt_x = COORD_W'(x); pt_y = COORD_W'(y); pt_core = core; epoch_done = ep;
        tick();
        idle();
    endtask

    task automatic clear_got();
        for (int i = 0; i < K; i++) begin
            got_x[i] = -1; got_y[i] = -1; got_e[i] = -1;
        end
    endtask

    function automatic logic [K-1:0] rand_core();
        logic [K-1:0] one;
        int r;
        one = 1;
        r = int'($urandom_range(0, 9));
        if (r == 0) return '0;
        if (r == 1) return K'($urandom);
        return one << $urandom_range(0, K - 1);
    endfunction

    // Run until pt_ready returns; random mode also jitters cen_ready and injects ignored inputs
    task automatic drain(input bit rnd, output int n);
        n = 0;
        cen_ready = 1'b1;
        while (!pt_ready && n < 6000) begin
            if (rnd) begin
                cen_ready  = ($urandom_range(0, 2) != 0);
                pt_valid   = $urandom_range(0, 1) != 0;
                pt_core    = rand_core();
                pt_x       = COORD_W'($urandom);
                pt_y       = COORD_W'($urandom);
                epoch_done = ($urandom_range(0, 7) == 0);
            end
            tick();
            n++;
        end
        idle();
        cen_ready = 1'b1;
        if (n >= 6000) chk("drain_timeout", 32'(n), 0);
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin : drv
        int n;
        rst = 1'b1;
        cen_ready = 1'b1;
        idle();
        clear_got();
        tick(); tick();
        rst = 1'b0;
        chk("rst_pt_ready", 32'(pt_ready), 1);
        chk("rst_cen_valid", 32'(cen_valid), 0);
        chk("rst_cen_idx", 32'(cen_idx), 0);
        chk("rst_cen_x", 32'(cen_x), 0);
        chk("rst_cen_y", 32'(cen_y), 0);
        chk("rst_cen_empty", 32'(cen_empty), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sat_err", 32'(sat_err), 0);

        // Two points to core 3, second together with epoch_done
        send(10, 20, 16'h0008, 1, 0);
        send(12, 22, 16'h0008, 1, 1);
        chk("busy_after_epoch", 32'(busy), 1);
        drain(0, n);
        chk("t1_drain_cycles", 32'(n), 32'(15 * 2 + DIV_W + 2));
        chk("t1_x3", 32'(got_x[3]), 11);
        chk("t1_y3", 32'(got_y[3]), 21);
        chk("t1_e3", 32'(got_e[3]), 0);
        chk("t1_e0", 32'(got_e[0]), 1);
        chk("t1_x0", 32'(got_x[0]), 0);
        chk("t1_y15", 32'(got_y[15]), 0);

        // Floor vs round-half-up
        clear_got();
        send(1, 0, 16'h0001, 1, 0);
        send(2, 0, 16'h0001, 1, 0);
        send(0, 0, '0, 0, 1);
        drain(0, n);
`ifdef CENTROID_ROUNDING_EN
        chk("t2_x0", 32'(got_x[0]), 2);
`else
        chk("t2_x0", 32'(got_x[0]), 1);
`endif

        // Multi-hot, zero-hot, and a point offered while dividing
        clear_got();
        send(5, 5, 16'h0006, 1, 0);
        send(40, 40, 16'h0000, 1, 0);
        send(0, 0, '0, 0, 1);
        pt_valid = 1'b1; pt_core = 16'h0002; pt_x = 6'd40; pt_y = 6'd40;
        tick(); tick(); tick();
        chk("t3_ready_in_divide", 32'(pt_ready), 0);
        idle();
        drain(0, n);
        chk("t3_x1", 32'(got_x[1]), 5);
        chk("t3_y1", 32'(got_y[1]), 5);
        chk("t3_e2", 32'(got_e[2]), 1);

        // Downstream stall on cluster 0
        clear_got();
        send(4, 8, 16'h0001, 1, 1);
        cen_ready = 1'b0;
        n = 0;
        while (!cen_valid && n < 100) begin
            tick();
            n++;
        end
        chk("t4_first_valid_lat", 32'(n), 32'(DIV_W + 1));
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t4_hold_idx", 32'(cen_idx), 0);
            chk("t4_hold_x", 32'(cen_x), 4);
        end
        drain(0, n);
        chk("t4_y0", 32'(got_y[0]), 8);
        clear_got();
        send(0, 0, '0, 0, 1);
        drain(0, n);
        chk("t4_empty_drain", 32'(n), 32'(K * 2));
        chk("t4_e0_after", 32'(got_e[0]), 1);

        // All clusters non-empty: full drain time
        clear_got();
        for (int i = 0; i < K; i++) begin
            logic [K-1:0] one;
            one = 1;
            send(i, 63 - i, one << i, 1, i == K - 1);
        end
        drain(0, n);
        chk("t5_full_drain", 32'(n), 32'(K * (DIV_W + 2)));
        chk("t5_x5", 32'(got_x[5]), 5);
        chk("t5_y5", 32'(got_y[5]), 58);

        // Counter saturation on cluster 2
        clear_got();
        for (int i = 0; i < CNT_MAX; i++) send(63, 63, 16'h0004, 1, 0);
        chk("t6_sat_before", 32'(sat_err), 0);
        send(63, 63, 16'h0004, 1, 0);
        chk("t6_sat_after", 32'(sat_err), 1);
        send(0, 0, '0, 0, 1);
        drain(0, n);
        chk("t6_x2", 32'(got_x[2]), 63);
        chk("t6_y2", 32'(got_y[2]), 63);
        chk("t6_e2", 32'(got_e[2]), 0);
        chk("t6_sat_cleared", 32'(sat_err), 0);

        // Reset while dividing
        for (int i = 0; i <= CNT_MAX; i++) send(63, 63, 16'h0004, 1, 0);
        send(0, 0, '0, 0, 1);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t7_busy", 32'(busy), 0);
        chk("t7_sat", 32'(sat_err), 0);
        chk("t7_valid", 32'(cen_valid), 0);
        chk("t7_ready", 32'(pt_ready), 1);
        clear_got();
        send(0, 0, '0, 0, 1);
        drain(0, n);
        chk("t7_e2_cleared", 32'(got_e[2]), 1);

        // Random epochs
        for (int e = 0; e < 8; e++) begin
            int npts;
            npts = int'($urandom_range(1, 40));
            for (int i = 0; i < npts; i++) begin
                send(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), rand_core(),
                     $urandom_range(0, 3) != 0, (i == npts - 1) && ($urandom_range(0, 1) != 0));
                if (!pt_ready) break;
            end
            if (pt_ready) send(0, 0, '0, 0, 1);
            drain(1, n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/centroid_updater.md
# centroid_updater

Consumer side of the closest-core interface in the K-means datapath. Receives each data point with its one-hot winning-core vector from the distance comparator, accumulates per-cluster coordinate sums and point counts over an epoch, then serially divides to produce the new centroid of every cluster. The new centroids stream out over a valid/ready handshake to the centroid register file.

## Interface
Parameters:
- `K`, 16: number of clusters/cores; width of the one-hot `pt_core`.
- `COORD_W`, 6: width of one point coordinate (unsigned).
- `CNT_W`, 12: width of each per-cluster point counter.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pt_valid`  in  1  point + assignment present.
- `pt_ready`  out  1  block accepts a point this cycle.
- `pt_x`, `pt_y`  in  COORD_W each  point coordinates.
- `pt_core`  in  K  one-hot closest core from the comparator.
- `epoch_done`  in  1  single-cycle pulse: last point of epoch delivered.
- `cen_valid`  out  1  new centroid present.
- `cen_ready`  in  1  downstream accepts centroid.
- `cen_idx`  out  $clog2(K)  cluster index of the centroid.
- `cen_x`, `cen_y`  out  COORD_W each  new centroid coordinates.
- `cen_empty`  out  1  cluster received zero points this epoch.
- `busy`  out  1  high in DIVIDE or EMIT.
- `sat_err`  out  1  sticky: a counter saturated this epoch.

## Operation
- Per cluster k: `sum_x[k]`, `sum_y[k]` (SUM_W = COORD_W+CNT_W bits), `cnt[k]` (CNT_W bits).
- States: ACCUM, DIVIDE, EMIT. Reset enters ACCUM.
- ACCUM: `pt_ready`=1. On `pt_valid & pt_ready`, cluster k = index of lowest set bit of `pt_core`; `sum_x[k]+=pt_x`, `sum_y[k]+=pt_y`, `cnt[k]+=1`. `pt_core`=0: point discarded, no state change. Multi-hot: lowest index wins (matches comparator tie rule).
- Saturation: if `cnt[k]` is all-ones, point discarded for that cluster, `sat_err` set; sums never overflow by construction.
- `epoch_done` in ACCUM -> DIVIDE with k=0. A point handshaken in the same cycle is included.
- DIVIDE: if `cnt[k]`=0, skip straight to EMIT with `cen_empty`=1, `cen_x`=`cen_y`=0. Otherwise run restoring divisions `sum_x[k]/cnt[k]` and `sum_y[k]/cnt[k]` in parallel, one quotient bit per cycle, SUM_W cycles; quotient truncated to COORD_W bits (always fits since mean ≤ max coordinate).
- EMIT: `cen_valid`=1 with stable `cen_idx`=k and data until `cen_ready`. On handshake: k<K-1 -> k+1, DIVIDE; k=K-1 -> clear all sums, counts and `sat_err`, return to ACCUM.
- `pt_ready`=0 in DIVIDE/EMIT; `epoch_done` outside ACCUM ignored.

## Timing
- Reset values: `pt_ready`=1 (after reset cycle), `cen_valid`=0, `cen_idx`=0, `cen_x`=`cen_y`=0, `cen_empty`=0, `busy`=0, `sat_err`=0; all accumulators 0.
- Accumulation throughput: one point per cycle; update visible the cycle after handshake.
- `busy` rises the cycle after `epoch_done`.
- Non-empty cluster: `cen_valid` asserts exactly SUM_W+1 cycles after entering DIVIDE for that cluster; empty cluster: 1 cycle.
- With `cen_ready` held high, an epoch of all-nonempty clusters drains in K·(SUM_W+2) cycles.
- `cen_*` outputs registered; no combinational path from `cen_ready` to `cen_valid` or from `pt_valid` to `pt_ready`.
- `rst` mid-DIVIDE/EMIT: abort immediately, accumulators cleared, `cen_valid` low next cycle, ACCUM.

## Configuration
- `CENTROID_ROUNDING_EN` defined: dividend is `sum + (cnt>>1)`, giving round-half-up mean; dividend width SUM_W+1, DIVIDE takes SUM_W+1 cycles; result clamped to 2^COORD_W−1.
- Undefined: truncating division (floor), SUM_W cycles, as above.

## Test plan
- Points (10,20),(12,22) to core 3 (`pt_core`=16'h0008), `epoch_done` -> cluster 3 emits `cen_x`=11, `cen_y`=21, `cen_empty`=0; all others emit `cen_empty`=1, x=y=0.
- Points (1,0),(2,0) to core 0 -> floor build `cen_x`=1; with `CENTROID_ROUNDING_EN` `cen_x`=2.
- `pt_core`=16'h0006 with point (5,5) -> credited to core 1 only; `pt_core`=0 point ignored entirely.
- `cen_ready` low 7 cycles during cluster 0 emit -> `cen_valid`, `cen_idx`, data stable; no advance until handshake; after index 15 handshake, `pt_ready`=1 and all counts read 0 on next epoch.
- `pt_valid` with `epoch_done` same cycle -> point included; `pt_valid` during DIVIDE -> `pt_ready`=0, point not accepted.
- 4095 points of (63,63) to core 2 then one more -> `sat_err`=1, cluster 2 emits (63,63); `rst` asserted mid-DIVIDE -> next cycle `busy`=0, `sat_err`=0, `cen_valid`=0.
